// File: rtl/vx_core_rsp_merge_if.sv
// Bank-to-core response bundle for vx_core_rsp_merge: per-bank response beats in,
// one merged core response beat out. The merge block takes the slave modport.
interface vx_core_rsp_merge_if #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned NUM_PORTS      = 1,
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned WORD_SIZE      = 4,
  parameter int unsigned CORE_TAG_WIDTH = 3
);
  localparam int unsigned WORD_WIDTH = 8 * WORD_SIZE;
  localparam int unsigned REQS_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_BANKS-1:0]                      per_bank_core_rsp_valid;
  logic [NUM_BANKS*NUM_PORTS-1:0]            per_bank_core_rsp_pmask;
  logic [NUM_BANKS*NUM_PORTS*WORD_WIDTH-1:0] per_bank_core_rsp_data;
  logic [NUM_BANKS*NUM_PORTS*REQS_BITS-1:0]  per_bank_core_rsp_tid;
  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]       per_bank_core_rsp_tag;
  logic [NUM_BANKS-1:0]                      per_bank_core_rsp_ready;

  logic                                      core_rsp_valid;
  logic [NUM_REQS-1:0]                       core_rsp_tmask;
  logic [NUM_REQS*WORD_WIDTH-1:0]            core_rsp_data;
  logic [CORE_TAG_WIDTH-1:0]                 core_rsp_tag;
  logic                                      core_rsp_ready;

  modport master (
    output per_bank_core_rsp_valid, per_bank_core_rsp_pmask, per_bank_core_rsp_data,
           per_bank_core_rsp_tid, per_bank_core_rsp_tag, core_rsp_ready,
    input  per_bank_core_rsp_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data,
           core_rsp_tag
  );

  modport slave (
    input  per_bank_core_rsp_valid, per_bank_core_rsp_pmask, per_bank_core_rsp_data,
           per_bank_core_rsp_tid, per_bank_core_rsp_tag, core_rsp_ready,
    output per_bank_core_rsp_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data,
           core_rsp_tag
  );
endinterface

// File: rtl/vx_core_rsp_merge.sv
// Merges same-tag bank responses into one registered core response beat per cycle.
// Optional perf counters (stalls, tid conflicts) under VX_CORE_RSP_MERGE_PERF_EN.
module vx_core_rsp_merge #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned NUM_PORTS      = 1,
  parameter int unsigned NUM_REQS       = 4,
  parameter int unsigned WORD_SIZE      = 4,
  parameter int unsigned CORE_TAG_WIDTH = 3,
  parameter int unsigned PERF_CTR_BITS  = 32
) (
  input  logic               clk,
  input  logic               reset,
  vx_core_rsp_merge_if.slave bus
`ifdef VX_CORE_RSP_MERGE_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_merge_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_merge_conflicts
`endif
);
  localparam int unsigned WORD_WIDTH = 8 * WORD_SIZE;
  localparam int unsigned REQS_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int unsigned RR_BITS    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                           core_valid_q;
  logic [NUM_REQS-1:0]            tmask_q, tmask_d;
  logic [NUM_REQS*WORD_WIDTH-1:0] data_q, data_d;
  logic [CORE_TAG_WIDTH-1:0]      tag_q, leader_tag;
  logic [RR_BITS-1:0]             rr_q, rr_d;

  logic [NUM_REQS-1:0]            bank_lanes [NUM_BANKS];
  logic [NUM_BANKS-1:0]           merge_mask;
  logic                           free, any_valid, conflict;
  int unsigned                    lead_idx;
  int unsigned                    lead_scan_b;
  int unsigned                    merge_scan_b;

  function automatic int unsigned rr_slot(input logic [RR_BITS-1:0] base, input int unsigned i);
    return (32'(base) + i) % NUM_BANKS;
  endfunction

  assign free = !core_valid_q || bus.core_rsp_ready;

  // Lanes each bank beat would claim, from its active ports' tids.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_lanes[b] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        for (int unsigned r = 0; r < NUM_REQS; r++) begin
          if (bus.per_bank_core_rsp_pmask[b*NUM_PORTS+p] &&
              bus.per_bank_core_rsp_tid[(b*NUM_PORTS+p)*REQS_BITS +: REQS_BITS] == REQS_BITS'(r))
            bank_lanes[b][r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_valid   = 1'b0;
    lead_idx    = 0;
    lead_scan_b = 0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      lead_scan_b = rr_slot(rr_q, i);
      if (!any_valid && bus.per_bank_core_rsp_valid[lead_scan_b]) begin
        any_valid = 1'b1;
        lead_idx  = lead_scan_b;
      end
    end
    leader_tag = bus.per_bank_core_rsp_tag[lead_idx*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
    rr_d       = any_valid ? RR_BITS'((lead_idx + 1) % NUM_BANKS) : rr_q;
  end

  // Members are taken in round-robin order; a later bank is dropped whole if any
  // of its lanes was already claimed, so each lane has exactly one writer.
  always_comb begin
    merge_mask   = '0;
    tmask_d      = '0;
    conflict     = 1'b0;
    merge_scan_b = 0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      merge_scan_b = rr_slot(rr_q, i);
      if (any_valid && bus.per_bank_core_rsp_valid[merge_scan_b] &&
          bus.per_bank_core_rsp_tag[merge_scan_b*CORE_TAG_WIDTH +: CORE_TAG_WIDTH] == leader_tag) begin
        if ((bank_lanes[merge_scan_b] & tmask_d) == '0) begin
          merge_mask[merge_scan_b] = 1'b1;
          tmask_d                  = tmask_d | bank_lanes[merge_scan_b];
        end else begin
          conflict = 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_d = data_q;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        for (int unsigned r = 0; r < NUM_REQS; r++) begin
          if (merge_mask[b] && bus.per_bank_core_rsp_pmask[b*NUM_PORTS+p] &&
              bus.per_bank_core_rsp_tid[(b*NUM_PORTS+p)*REQS_BITS +: REQS_BITS] == REQS_BITS'(r))
            data_d[r*WORD_WIDTH +: WORD_WIDTH] =
              bus.per_bank_core_rsp_data[(b*NUM_PORTS+p)*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  // Readies depend only on the output register and bank inputs, never on core ready paths
  // beyond the free term; reset forces them low while the register is clearing.
  assign bus.per_bank_core_rsp_ready = (free && !reset) ? merge_mask : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_valid_q <= 1'b0;
      tmask_q      <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      rr_q         <= '0;
    end else if (free) begin
      if (any_valid) begin
        core_valid_q <= 1'b1;
        tag_q        <= leader_tag;
        tmask_q      <= tmask_d;
        data_q       <= data_d;
        rr_q         <= rr_d;
      end else begin
        core_valid_q <= 1'b0;
      end
    end
  end

  assign bus.core_rsp_valid = core_valid_q;
  assign bus.core_rsp_tmask = tmask_q;
  assign bus.core_rsp_data  = data_q;
  assign bus.core_rsp_tag   = tag_q;

`ifdef VX_CORE_RSP_MERGE_PERF_EN
  logic [PERF_CTR_BITS-1:0] stalls_q, conflicts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalls_q    <= '0;
      conflicts_q <= '0;
    end else begin
      if (core_valid_q && !bus.core_rsp_ready && stalls_q != '1)
        stalls_q <= stalls_q + 1'b1;
      if (free && conflict && conflicts_q != '1)
        conflicts_q <= conflicts_q + 1'b1;
    end
  end

  assign perf_merge_stalls    = stalls_q;
  assign perf_merge_conflicts = conflicts_q;
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_vx_core_rsp_merge.sv
// Scoreboard bench for vx_core_rsp_merge: directed cases then randomized traffic.
module tb_vx_core_rsp_merge;
  localparam int unsigned NB = 4, NP = 1, NR = 4, WS = 4, TW = 3;
  localparam int unsigned WW = 8 * WS;
  localparam int unsigned RB = 2;

  typedef struct {
    logic [TW-1:0]    tag;
    logic [NR-1:0]    tmask;
    logic [NR*WW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_core_rsp_merge_if #(.NUM_BANKS(NB), .NUM_PORTS(NP), .NUM_REQS(NR),
                         .WORD_SIZE(WS), .CORE_TAG_WIDTH(TW)) bus ();

`ifdef VX_CORE_RSP_MERGE_PERF_EN
  logic [31:0] perf_stalls, perf_conflicts;
`endif

  vx_core_rsp_merge #(.NUM_BANKS(NB), .NUM_PORTS(NP), .NUM_REQS(NR),
                      .WORD_SIZE(WS), .CORE_TAG_WIDTH(TW), .PERF_CTR_BITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VX_CORE_RSP_MERGE_PERF_EN
    ,
    .perf_merge_stalls    (perf_stalls),
    .perf_merge_conflicts (perf_conflicts)
`endif
  );

  // Bank-side stimulus state (one port per bank)
  logic          bv   [NB];
  logic          bpm  [NB];
  logic [RB-1:0] btid [NB];
  logic [TW-1:0] btag [NB];
  logic [WW-1:0] bdat [NB];
  logic          core_ready;
  logic [NB-1:0] consumed;
  bit            random_mode;

  // Reference model state
  logic          mvalid;
  int unsigned   mrr;
  logic [WW-1:0] mdata [NR];
  beat_t         exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    for (int unsigned b = 0; b < NB; b++) begin
      bus.per_bank_core_rsp_valid[b]          = bv[b];
      bus.per_bank_core_rsp_pmask[b]          = bpm[b];
      bus.per_bank_core_rsp_tid[b*RB +: RB]   = btid[b];
      bus.per_bank_core_rsp_tag[b*TW +: TW]   = btag[b];
      bus.per_bank_core_rsp_data[b*WW +: WW]  = bdat[b];
    end
    bus.core_rsp_ready = core_ready;
  endtask

  task automatic set_bank(input int unsigned b, input logic pm, input logic [RB-1:0] tid,
                          input logic [TW-1:0] tag, input logic [WW-1:0] dat);
    bv[b] = 1'b1; bpm[b] = pm; btid[b] = tid; btag[b] = tag; bdat[b] = dat;
  endtask

  task automatic new_beat(input int unsigned b);
    set_bank(b, $urandom_range(0, 7) != 0, RB'($urandom_range(0, NR - 1)),
             TW'($urandom_range(0, 2)), $urandom);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mvalid = 1'b0;
    mrr    = 0;
    for (int unsigned r = 0; r < NR; r++) mdata[r] = '0;
  endtask

  // Evaluates the cycle about to be clocked: expected readies now, expected beat queued.
  task automatic model_step();
    logic          free_m, found;
    int unsigned   lead, b;
    logic [NR-1:0] claimed, lanes;
    logic [NB-1:0] exp_rdy;
    beat_t         e;
    free_m  = !mvalid || core_ready;
    found   = 1'b0;
    lead    = 0;
    exp_rdy = '0;
    claimed = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      b = (mrr + i) % NB;
      if (bv[b] && !found) begin found = 1'b1; lead = b; end
    end
    if (free_m && found) begin
      for (int unsigned i = 0; i < NB; i++) begin
        b = (lead + i) % NB;
        if (bv[b] && btag[b] == btag[lead]) begin
          lanes = bpm[b] ? (NR'(1) << btid[b]) : '0;
          if ((lanes & claimed) == '0) begin
            exp_rdy[b] = 1'b1;
            claimed    = claimed | lanes;
            if (bpm[b]) mdata[btid[b]] = bdat[b];
          end
        end
      end
      e.tag   = btag[lead];
      e.tmask = claimed;
      e.data  = '0;
      for (int unsigned r = 0; r < NR; r++) e.data[r*WW +: WW] = mdata[r];
      exp_q.push_back(e);
      mvalid = 1'b1;
      mrr    = (lead + 1) % NB;
    end else if (free_m) begin
      mvalid = 1'b0;
    end
    chk("bank_ready", 128'(bus.per_bank_core_rsp_ready), 128'(exp_rdy));
    consumed = exp_rdy;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int unsigned b = 0; b < NB; b++) begin
      if (consumed[b]) begin
        if (random_mode) new_beat(b);
        else bv[b] = 1'b0;
      end else if (random_mode && !bv[b] && $urandom_range(0, 3) == 0) begin
        new_beat(b);
      end
    end
    if (random_mode) core_ready = ($urandom_range(0, 3) != 0);
    drive_bus();
    chk("core_rsp_valid", 128'(bus.core_rsp_valid), 128'(mvalid));
  endtask

  task automatic clear_banks();
    for (int unsigned b = 0; b < NB; b++) begin
      bv[b] = 1'b0; bpm[b] = 1'b0; btid[b] = '0; btag[b] = '0; bdat[b] = '0;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted core beat
  always @(negedge clk) begin
    if (!reset && bus.core_rsp_valid && bus.core_rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got tag %h tmask %b, expected no beat",
                 bus.core_rsp_tag, bus.core_rsp_tmask);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (bus.core_rsp_tag !== e.tag || bus.core_rsp_tmask !== e.tmask ||
            bus.core_rsp_data !== e.data) begin
          errors++;
          $display("FAIL beat: got tag %h tmask %b data %h, expected tag %h tmask %b data %h",
                   bus.core_rsp_tag, bus.core_rsp_tmask, bus.core_rsp_data,
                   e.tag, e.tmask, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic          s_valid;
    logic [NR-1:0] s_tmask;
    logic [127:0]  s_data;
    logic [TW-1:0] s_tag;

    random_mode = 0;
    core_ready  = 1'b1;
    consumed    = '0;
    clear_banks();
    set_bank(0, 1'b1, 2'd1, 3'd2, 32'h1234_5678);
    drive_bus();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 128'(bus.core_rsp_valid), 128'(0));
    chk("reset_tmask", 128'(bus.core_rsp_tmask), 128'(0));
    chk("reset_data",  128'(bus.core_rsp_data),  128'(0));
    chk("reset_tag",   128'(bus.core_rsp_tag),   128'(0));
    chk("reset_ready", 128'(bus.per_bank_core_rsp_ready), 128'(0));
    clear_banks();
    drive_bus();
    reset = 1'b0;
    cycle();

    // Single bank, lane 3
    set_bank(2, 1'b1, 2'd3, 3'd5, 32'hAAAA_0003);
    drive_bus();
    repeat (3) cycle();

    // Four banks, same tag, distinct lanes
    for (int unsigned b = 0; b < NB; b++) set_bank(b, 1'b1, RB'(b), 3'd2, 32'hB000_0000 + b);
    drive_bus();
    repeat (3) cycle();

    // Different tags: two beats back to back
    set_bank(0, 1'b1, 2'd0, 3'd1, 32'hC000_0000);
    set_bank(1, 1'b1, 2'd1, 3'd4, 32'hC000_0001);
    drive_bus();
    repeat (4) cycle();

    // Same tag, colliding lane: second bank retries
    set_bank(0, 1'b1, 2'd2, 3'd6, 32'hD000_0000);
    set_bank(1, 1'b1, 2'd2, 3'd6, 32'hD000_0001);
    drive_bus();
    repeat (4) cycle();

    // pmask=0 beat is consumed with an empty lane mask
    set_bank(3, 1'b0, 2'd1, 3'd7, 32'hE000_0000);
    drive_bus();
    repeat (2) cycle();

    // Backpressure: beat held for 3 cycles
    set_bank(1, 1'b1, 2'd1, 3'd3, 32'hF000_0001);
    set_bank(3, 1'b1, 2'd1, 3'd3, 32'hF000_0003);
    drive_bus();
    cycle();
    core_ready = 1'b0;
    drive_bus();
    s_valid = bus.core_rsp_valid;
    s_tmask = bus.core_rsp_tmask;
    s_data  = 128'(bus.core_rsp_data);
    s_tag   = bus.core_rsp_tag;
    repeat (3) begin
      cycle();
      chk("stall_valid", 128'(bus.core_rsp_valid), 128'(1));
      chk("stall_hold",  {s_valid, s_tag, s_tmask, s_data[119:0]},
          {bus.core_rsp_valid, bus.core_rsp_tag, bus.core_rsp_tmask, bus.core_rsp_data[119:0]});
    end
    core_ready = 1'b1;
    drive_bus();
    repeat (3) cycle();

    // Reset while a beat is held; pending banks re-emitted from bank 0
    core_ready = 1'b0;
    set_bank(0, 1'b1, 2'd0, 3'd1, 32'h5000_0000);
    set_bank(1, 1'b1, 2'd1, 3'd2, 32'h5000_0001);
    set_bank(2, 1'b1, 2'd2, 3'd1, 32'h5000_0002);
    set_bank(3, 1'b1, 2'd3, 3'd2, 32'h5000_0003);
    drive_bus();
    cycle();
    set_bank(2, 1'b1, 2'd2, 3'd1, 32'h5000_0022);
    drive_bus();
    reset = 1'b1;
    #1;
    chk("midreset_valid", 128'(bus.core_rsp_valid), 128'(0));
    chk("midreset_ready", 128'(bus.per_bank_core_rsp_ready), 128'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    core_ready = 1'b1;
    drive_bus();
    repeat (6) cycle();

    // Randomized traffic
    random_mode = 1;
    repeat (2000) cycle();
    random_mode = 0;
    core_ready  = 1'b1;
    for (int unsigned b = 0; b < NB; b++) bv[b] = 1'b0;
    drive_bus();
    repeat (4) cycle();
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end
endmodule
